// File: rtl/mem_bus_arbiter.sv
// Round-robin N-master byte bus arbiter with RAM / I/O window decode and one-cycle read return.
// Grant one cycle after request, 1 beat/cycle while owned; I/O writes stall (no ack) while io_full.
module mem_bus_arbiter #(
   parameter int ADDR_WIDTH = 17,
   parameter int N_MASTERS  = 2,
   parameter bit PRIO0      = 1'b1,
   parameter int MAX_BURST  = 16
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic [N_MASTERS-1:0]    m_req,
   input  logic [32*N_MASTERS-1:0] m_a,
   input  logic [N_MASTERS-1:0]    m_wr,
   input  logic [8*N_MASTERS-1:0]  m_dout,
   output logic [N_MASTERS-1:0]    m_gnt,
   output logic [N_MASTERS-1:0]    m_ack,
   output logic [N_MASTERS-1:0]    m_rvalid,
   output logic [7:0]              m_din,
   output logic                    ram_en,
   output logic                    ram_r_nw,
   output logic [ADDR_WIDTH-1:0]   ram_a,
   output logic [7:0]              ram_d_out,
   input  logic [7:0]              ram_d_in,
   output logic                    io_en,
   output logic                    io_wr,
   output logic [2:0]              io_sel,
   output logic [7:0]              io_din,
   input  logic [7:0]              io_dout,
   input  logic                    io_full
);

   localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

   typedef enum logic {ST_IDLE, ST_OWN} state_t;

   state_t          r_state;
   logic [IW-1:0]   r_owner;
   logic [IW-1:0]   r_last;
   logic [IW-1:0]   r_ridx;
   logic [7:0]      r_cnt;
   logic            r_rvalid;
   logic            r_rio;

   logic                w_owned;
   logic [ADDR_WIDTH:0] w_a;
   logic                w_wr;
   logic                w_req;
   logic [7:0]          w_wdat;
   logic                w_io;
   logic                w_stall;
   logic                w_ack;
   logic [IW-1:0]       w_k;
   logic [IW-1:0]       w_pick;

   always_comb begin
      w_owned = (r_state == ST_OWN);
      w_a     = m_a[32*int'(r_owner) +: ADDR_WIDTH+1];
      w_wr    = m_wr[r_owner];
      w_req   = m_req[r_owner];
      w_wdat  = m_dout[8*int'(r_owner) +: 8];
      w_io    = (w_a[ADDR_WIDTH -: 2] == 2'b11);
      w_stall = w_io & w_wr & io_full;
      w_ack   = w_owned & w_req & ~w_stall;
   end

   // Scan from farthest to nearest so the master right after r_last wins.
   always_comb begin
      w_pick = r_last;
      w_k    = '0;
      for (int i = N_MASTERS; i >= 1; i--) begin
         w_k = IW'((int'(r_last) + i) % N_MASTERS);
         if (m_req[w_k]) w_pick = w_k;
      end
      if (PRIO0 && m_req[0]) w_pick = '0;
   end

   always_comb begin
      m_gnt     = '0;
      m_ack     = '0;
      m_rvalid  = '0;
      m_din     = 8'h00;
      ram_en    = 1'b0;
      ram_r_nw  = 1'b1;
      ram_a     = '0;
      ram_d_out = 8'h00;
      io_en     = 1'b0;
      io_wr     = 1'b0;
      io_sel    = 3'b000;
      io_din    = 8'h00;
      if (w_owned) begin
         m_gnt[r_owner] = 1'b1;
         m_ack[r_owner] = w_ack;
         ram_en         = w_ack & ~w_io;
         io_en          = w_ack & w_io;
         ram_r_nw       = ~w_wr;
         io_wr          = w_wr;
         ram_a          = w_a[ADDR_WIDTH-1:0];
         io_sel         = w_a[2:0];
         ram_d_out      = w_wdat;
         io_din         = w_wdat;
      end
      // Return mux follows the flag captured with the beat, not today's decode.
      if (r_rvalid) begin
         m_rvalid[r_ridx] = 1'b1;
         m_din            = r_rio ? io_dout : ram_d_in;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state  <= ST_IDLE;
         r_owner  <= '0;
         r_last   <= IW'(N_MASTERS-1);
         r_cnt    <= 8'd0;
         r_rvalid <= 1'b0;
         r_ridx   <= '0;
         r_rio    <= 1'b0;
      end else begin
         r_rvalid <= w_ack & ~w_wr;
         if (w_ack) begin
            r_ridx <= r_owner;
            r_rio  <= w_io;
         end
         case (r_state)
            ST_IDLE: begin
               r_cnt <= 8'd0;
               if (|m_req) begin
                  r_owner <= w_pick;
                  r_state <= ST_OWN;
               end
            end
            ST_OWN: begin
               if (w_ack) r_cnt <= r_cnt + 8'd1;
               if (!w_req || (w_ack && r_cnt == 8'(MAX_BURST-1))) begin
                  r_state <= ST_IDLE;
                  r_last  <= r_owner;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: a PRIO0=1 instance and a round-robin instance share all inputs, N=3, MAX_BURST=4.
module tb_mem_bus_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  req;
   logic [95:0] a;
   logic [2:0]  wr;
   logic [23:0] dout;
   logic [7:0]  ram_d_in;
   logic [7:0]  io_dout;
   logic        io_full;

   logic [2:0]  p_gnt, p_ack, p_rvalid, p_io_sel;
   logic [7:0]  p_din, p_ram_d_out, p_io_din;
   logic        p_ram_en, p_ram_r_nw, p_io_en, p_io_wr;
   logic [16:0] p_ram_a;

   logic [2:0]  q_gnt, q_ack, q_rvalid, q_io_sel;
   logic [7:0]  q_din, q_ram_d_out, q_io_din;
   logic        q_ram_en, q_ram_r_nw, q_io_en, q_io_wr;
   logic [16:0] q_ram_a;

   int total = 0;
   int bad   = 0;

   mem_bus_arbiter #(.ADDR_WIDTH(17), .N_MASTERS(3), .PRIO0(1'b1), .MAX_BURST(4)) u_pr (
      .clk_in(clk), .rst_in(rst), .m_req(req), .m_a(a), .m_wr(wr), .m_dout(dout),
      .m_gnt(p_gnt), .m_ack(p_ack), .m_rvalid(p_rvalid), .m_din(p_din),
      .ram_en(p_ram_en), .ram_r_nw(p_ram_r_nw), .ram_a(p_ram_a), .ram_d_out(p_ram_d_out),
      .ram_d_in(ram_d_in), .io_en(p_io_en), .io_wr(p_io_wr), .io_sel(p_io_sel),
      .io_din(p_io_din), .io_dout(io_dout), .io_full(io_full)
   );

   mem_bus_arbiter #(.ADDR_WIDTH(17), .N_MASTERS(3), .PRIO0(1'b0), .MAX_BURST(4)) u_rr (
      .clk_in(clk), .rst_in(rst), .m_req(req), .m_a(a), .m_wr(wr), .m_dout(dout),
      .m_gnt(q_gnt), .m_ack(q_ack), .m_rvalid(q_rvalid), .m_din(q_din),
      .ram_en(q_ram_en), .ram_r_nw(q_ram_r_nw), .ram_a(q_ram_a), .ram_d_out(q_ram_d_out),
      .ram_d_in(ram_d_in), .io_en(q_io_en), .io_wr(q_io_wr), .io_sel(q_io_sel),
      .io_din(q_io_din), .io_dout(io_dout), .io_full(io_full)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] pe, qe, pa, qa;
      rst = 1'b1; req = 3'b000; a = '0; wr = 3'b000; dout = '0;
      ram_d_in = 8'h00; io_dout = 8'h00; io_full = 1'b0;
      #2;
      chk("rst_gnt", p_gnt, 3'b000);
      chk("rst_ack", p_ack, 3'b000);
      chk("rst_rvalid", p_rvalid, 3'b000);
      chk("rst_din", p_din, 8'h00);
      chk("rst_ram_en", p_ram_en, 1'b0);
      chk("rst_ram_r_nw", p_ram_r_nw, 1'b1);
      chk("rst_io_en", p_io_en, 1'b0);
      chk("rst_io_wr", p_io_wr, 1'b0);
      cyc();
      cyc();
      rst = 1'b0;

      // Masters 1 and 2 stream RAM reads: bursts of 4 with a one-cycle gap, 1,2,1.
      a[32 +: 32] = 32'h0000_0100;
      a[64 +: 32] = 32'h0000_0200;
      for (int c = 0; c < 15; c++) begin
         cyc();
         if (c == 0) req = 3'b110;
         #1;
         if (c % 5 == 0) pe = 3'b000;
         else if (c >= 6 && c <= 9) pe = 3'b100;
         else pe = 3'b010;
         chk("rr_gnt_pr", p_gnt, pe);
         chk("rr_ack_pr", p_ack, pe);
         chk("rr_gnt_rr", q_gnt, pe);
         chk("rr_ack_rr", q_ack, pe);
      end

      // Single master 1 RAM read with one-cycle return.
      cyc();
      req = 3'b010; a[32 +: 32] = 32'h0000_0010; ram_d_in = 8'hA5;
      #1;
      chk("rd_gnt_wait", p_gnt, 3'b000);
      cyc(); #1;
      chk("rd_gnt", p_gnt, 3'b010);
      chk("rd_ack", p_ack, 3'b010);
      chk("rd_ram_en", p_ram_en, 1'b1);
      chk("rd_ram_a", p_ram_a, 17'h00010);
      chk("rd_ram_r_nw", p_ram_r_nw, 1'b1);
      chk("rd_io_en", p_io_en, 1'b0);
      cyc();
      req = 3'b000;
      #1;
      chk("rd_rvalid", p_rvalid, 3'b010);
      chk("rd_din", p_din, 8'hA5);
      chk("rd_ack_drop", p_ack, 3'b000);
      cyc(); #1;
      chk("rd_idle_gnt", p_gnt, 3'b000);
      chk("rd_idle_rvalid", p_rvalid, 3'b000);
      chk("rd_idle_din", p_din, 8'h00);

      // Master 0 and 2 join mid-burst of master 1; prio instance serves 0, round-robin serves 2.
      a[0 +: 32]  = 32'h0000_0040;
      a[32 +: 32] = 32'h0000_0020;
      a[64 +: 32] = 32'h0000_0060;
      for (int c = 0; c < 14; c++) begin
         cyc();
         if (c == 0) req = 3'b010;
         if (c == 1) req = 3'b111;
         if (c == 12) req = 3'b000;
         #1;
         if (c == 0 || c == 5 || c == 10 || c == 13) begin pe = 3'b000; qe = 3'b000; end
         else if (c <= 4) begin pe = 3'b010; qe = 3'b010; end
         else if (c <= 9) begin pe = 3'b001; qe = 3'b100; end
         else begin pe = 3'b001; qe = 3'b001; end
         pa = (c == 12) ? 3'b000 : pe;
         qa = (c == 12) ? 3'b000 : qe;
         chk("pr_gnt", p_gnt, pe);
         chk("pr_ack", p_ack, pa);
         chk("pr_gnt_rr", q_gnt, qe);
         chk("pr_ack_rr", q_ack, qa);
      end

      // I/O write from master 1 held off by io_full for three cycles.
      cyc();
      req = 3'b010; wr = 3'b010; a[32 +: 32] = 32'h0003_0000; dout[8 +: 8] = 8'h41; io_full = 1'b1;
      #1;
      chk("io_gnt_wait", p_gnt, 3'b000);
      for (int c = 0; c < 3; c++) begin
         cyc(); #1;
         chk("io_stall_gnt", p_gnt, 3'b010);
         chk("io_stall_ack", p_ack, 3'b000);
         chk("io_stall_en", p_io_en, 1'b0);
      end
      cyc();
      io_full = 1'b0;
      #1;
      chk("io_ack", p_ack, 3'b010);
      chk("io_en", p_io_en, 1'b1);
      chk("io_wr", p_io_wr, 1'b1);
      chk("io_din", p_io_din, 8'h41);
      chk("io_sel", p_io_sel, 3'd0);
      chk("io_ram_en", p_ram_en, 1'b0);
      cyc();
      req = 3'b000; wr = 3'b000;
      #1;
      chk("io_done_ack", p_ack, 3'b000);
      chk("io_done_en", p_io_en, 1'b0);
      chk("io_no_rvalid", p_rvalid, 3'b000);

      // Master 2: RAM read then I/O read back to back, io_full set but irrelevant for reads.
      cyc();
      req = 3'b100; a[64 +: 32] = 32'h0000_0004; io_full = 1'b1;
      ram_d_in = 8'h3C; io_dout = 8'hC3;
      #1;
      chk("rr2_gnt_wait", p_gnt, 3'b000);
      cyc(); #1;
      chk("rr2_ack_ram", p_ack, 3'b100);
      chk("rr2_ram_en", p_ram_en, 1'b1);
      chk("rr2_ram_a", p_ram_a, 17'h00004);
      chk("rr2_io_en0", p_io_en, 1'b0);
      cyc();
      a[64 +: 32] = 32'h0003_0004;
      #1;
      chk("rr2_ack_io", p_ack, 3'b100);
      chk("rr2_io_en", p_io_en, 1'b1);
      chk("rr2_ram_en0", p_ram_en, 1'b0);
      chk("rr2_io_sel", p_io_sel, 3'd4);
      chk("rr2_rvalid_ram", p_rvalid, 3'b100);
      chk("rr2_din_ram", p_din, 8'h3C);
      cyc();
      req = 3'b000; a[64 +: 32] = 32'h0000_0004;
      #1;
      chk("rr2_rvalid_io", p_rvalid, 3'b100);
      chk("rr2_din_io", p_din, 8'hC3);
      cyc(); #1;
      chk("rr2_rvalid_end", p_rvalid, 3'b000);

      // Reset in the middle of a master-1 burst with a read return pending.
      req = 3'b010; a[32 +: 32] = 32'h0000_0008; io_full = 1'b0;
      cyc(); #1;
      chk("mr_ack", p_ack, 3'b010);
      cyc();
      chk("mr_pending", p_rvalid, 3'b010);
      rst = 1'b1; req = 3'b011;
      #1;
      chk("mr_gnt", p_gnt, 3'b000);
      chk("mr_ack0", p_ack, 3'b000);
      chk("mr_rvalid", p_rvalid, 3'b000);
      chk("mr_din", p_din, 8'h00);
      chk("mr_ram_en", p_ram_en, 1'b0);
      chk("mr_ram_r_nw", p_ram_r_nw, 1'b1);
      chk("mr_ram_a", p_ram_a, 17'h00000);
      chk("mr_io_en", p_io_en, 1'b0);
      chk("mr_io_wr", p_io_wr, 1'b0);
      cyc(); #1;
      chk("mr_hold_gnt", p_gnt, 3'b000);
      chk("mr_hold_rvalid", p_rvalid, 3'b000);
      rst = 1'b0;
      cyc(); #1;
      chk("post_gnt_pr", p_gnt, 3'b001);
      chk("post_gnt_rr", q_gnt, 3'b001);
      chk("post_rvalid", p_rvalid, 3'b000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
